writeback: RTL and testbench

//  Final pipeline stage, downstream of execute. Accepts {rd_num, wb, rd_data} from EX
//  via the v/stall pipeline handshake. Queues writes in a DEPTH-entry FIFO and drains

---
 rtl/writeback_pkg.sv | 24 ++
 rtl/writeback_if.sv | 35 +++
 rtl/writeback_queue.sv | 90 +++++++++
 rtl/writeback.sv | 86 ++++++++
 tb/tb_writeback.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/writeback_pkg.sv
// rtl/writeback_pkg.sv - shared widths and write-queue entry layout for the writeback stage
//
// Purpose: single home for the data/register widths and the {rd_num, data} entry
// layout used by the writeback top, its queue and its bus interface.
// Ports: none (package).

package writeback_pkg;

  localparam int WORD      = 32;
  localparam int W_RD      = 5;
  localparam int W_WBQ_ENT = W_RD + WORD;

  typedef struct packed {
    logic [W_RD-1:0] rd_num;
    logic [WORD-1:0] data;
  } wb_ent_t;

  // r0 is hard-wired zero, so a result only needs a register-file write when it
  // both asks for one and targets a real register.
  function automatic logic writes_reg(input logic wb, input logic [W_RD-1:0] rd_num);
    return wb && (rd_num != '0);
  endfunction

endpackage

// File: rtl/writeback_if.sv
// rtl/writeback_if.sv - EX-to-writeback handshake and register-file write port bundle
//
// Purpose: groups the EX result handshake (v/stall) and the register-file
// req/ack write port into one interface.
// Signals:
//   v_i, rd_num_i, wb_i, rd_data_i  EX result and its valid
//   stall_o                         back to EX, 1 = hold
//   rf_we_o, rf_num_o, rf_data_o    register-file write request
//   rf_ack_i                        register file took the write this cycle
// Modports: slave = writeback stage, master = the EX/regfile side driving it.

interface writeback_if;
  import writeback_pkg::*;

  logic            v_i;
  logic            stall_o;
  logic [W_RD-1:0] rd_num_i;
  logic            wb_i;
  logic [WORD-1:0] rd_data_i;
  logic            rf_we_o;
  logic [W_RD-1:0] rf_num_o;
  logic [WORD-1:0] rf_data_o;
  logic            rf_ack_i;

  modport slave (
    input  v_i, rd_num_i, wb_i, rd_data_i, rf_ack_i,
    output stall_o, rf_we_o, rf_num_o, rf_data_o
  );

  modport master (
    output v_i, rd_num_i, wb_i, rd_data_i, rf_ack_i,
    input  stall_o, rf_we_o, rf_num_o, rf_data_o
  );

endinterface

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - parametric synchronous FIFO of pending register writes
//
// Purpose: holds accepted writes in order until the register file acknowledges
// them; exposes per-entry valid bits and rd_num taps for the hazard compare.
// Ports:
//   clk, rst            clock, synchronous active-high reset (empties the queue)
//   push, push_ent      write push_ent at tail (ignored when full)
//   pop                 drop the head entry (ignored when empty)
//   head_ent            entry at head
//   full, empty         occupancy flags from the registered count
//   ent_valid           per-slot occupied bits
//   ent_rd_num          per-slot destination register taps

module writeback_queue
  import writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  wb_ent_t                    push_ent,
  input  logic                       pop,
  output wb_ent_t                    head_ent,
  output logic                       full,
  output logic                       empty,
  output logic [DEPTH-1:0]           ent_valid,
  output logic [DEPTH-1:0][W_RD-1:0] ent_rd_num
);

  localparam int W_PTR   = $clog2(DEPTH);
  localparam int W_COUNT = W_PTR + 1;

  wb_ent_t            mem [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic [W_PTR-1:0]   head;
  logic [W_PTR-1:0]   tail;
  logic [W_COUNT-1:0] count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == W_COUNT'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two. head==tail with
  // both push and pop active cannot occur: that needs empty or full, and each
  // of those blocks one side.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (do_push) begin
        tail        <= tail + W_PTR'(1);
        valid[tail] <= 1'b1;
      end
      if (do_pop) begin
        head        <= head + W_PTR'(1);
        valid[head] <= 1'b0;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + W_COUNT'(1);
        2'b01:   count <= count - W_COUNT'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; slots are only read when their valid bit is set.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail] <= push_ent;
    end
  end

  assign head_ent  = mem[head];
  assign ent_valid = valid;

  always_comb begin
    ent_rd_num = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd_num[i] = mem[i].rd_num;
    end
  end

endmodule

// File: rtl/writeback.sv
// rtl/writeback.sv - final pipeline stage: queues EX results and drains them to the register file
//
// Purpose: accepts EX results on the v/stall handshake, queues register writes,
// issues them to the register file with req/ack, flags pending-write hazards for
// ID and counts retired instructions.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   bus         writeback_if.slave: EX handshake in, register-file write port out
//   chk_num_i   register ID is about to read
//   hazard_o    a queued write targets chk_num_i
//   retired_o   number of accepted EX results, wraps

module writeback
  import writeback_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W_CNT = 32
) (
  input  logic             clk,
  input  logic             rst,
  writeback_if.slave       bus,
  input  logic [W_RD-1:0]  chk_num_i,
  output logic             hazard_o,
  output logic [W_CNT-1:0] retired_o
);

  wb_ent_t                    push_ent;
  wb_ent_t                    head_ent;
  logic                       full;
  logic                       empty;
  logic                       accept;
  logic                       push;
  logic                       pop;
  logic [DEPTH-1:0]           ent_valid;
  logic [DEPTH-1:0][W_RD-1:0] ent_rd_num;

  // stall depends only on registered occupancy, so a same-cycle pop never
  // admits a push into a full queue; EX sees the slot one cycle later.
  assign bus.stall_o = full;
  assign accept      = bus.v_i && !full;
  assign push        = accept && writes_reg(bus.wb_i, bus.rd_num_i);
  assign pop         = bus.rf_ack_i && !empty;

  assign push_ent.rd_num = bus.rd_num_i;
  assign push_ent.data   = bus.rd_data_i;

  writeback_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_ent   (push_ent),
    .pop        (pop),
    .head_ent   (head_ent),
    .full       (full),
    .empty      (empty),
    .ent_valid  (ent_valid),
    .ent_rd_num (ent_rd_num)
  );

  // Head payload is forced to zero when empty so the port shows no stale data.
  assign bus.rf_we_o   = !empty;
  assign bus.rf_num_o  = empty ? '0 : head_ent.rd_num;
  assign bus.rf_data_o = empty ? '0 : head_ent.data;

  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_rd_num[i] == chk_num_i)) begin
        hazard_o = 1'b1;
      end
    end
    // Reads of r0 never wait on a write.
    if (chk_num_i == '0) begin
      hazard_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_o <= '0;
    end else if (accept) begin
      retired_o <= retired_o + W_CNT'(1);
    end
  end

endmodule

// File: tb/tb_writeback.sv
// tb/tb_writeback.sv - directed and randomized bench for writeback against a queue model

module tb_writeback;
  import writeback_pkg::*;

  localparam int DEPTH = 2;
  localparam int W_CNT = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [W_RD-1:0]  chk_num;
  logic             hazard;
  logic [W_CNT-1:0] retired;

  writeback_if bus ();

  writeback #(.DEPTH(DEPTH), .W_CNT(W_CNT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .chk_num_i (chk_num),
    .hazard_o  (hazard),
    .retired_o (retired)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference: in-order list of writes still owed to the register file.
  wb_ent_t          mq[$];
  logic [W_CNT-1:0] m_retired = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check the settled outputs against the model,
  // then advance the model and the DUT across one clock edge.
  task automatic step(input logic v, input logic wb, input logic [W_RD-1:0] rd,
                      input logic [WORD-1:0] data, input logic ack,
                      input logic [W_RD-1:0] chk, input logic r);
    logic    exp_haz;
    wb_ent_t ent;
    bus.v_i       = v;
    bus.wb_i      = wb;
    bus.rd_num_i  = rd;
    bus.rd_data_i = data;
    bus.rf_ack_i  = ack;
    chk_num       = chk;
    rst           = r;
    #1;
    exp_haz = 1'b0;
    foreach (mq[i]) if (mq[i].rd_num == chk) exp_haz = 1'b1;
    if (chk == 0) exp_haz = 1'b0;
    check("stall",   64'(bus.stall_o),   64'(mq.size() == DEPTH));
    check("rf_we",   64'(bus.rf_we_o),   64'(mq.size() != 0));
    check("rf_num",  64'(bus.rf_num_o),  mq.size() != 0 ? 64'(mq[0].rd_num) : 64'd0);
    check("rf_data", 64'(bus.rf_data_o), mq.size() != 0 ? 64'(mq[0].data) : 64'd0);
    check("hazard",  64'(hazard),        64'(exp_haz));
    check("retired", 64'(retired),       64'(m_retired));
    if (r) begin
      mq.delete();
      m_retired = '0;
    end else begin
      logic was_full;
      was_full = (mq.size() == DEPTH);
      if (ack && mq.size() != 0) void'(mq.pop_front());
      if (v && !was_full) begin
        m_retired++;
        if (wb && rd != 0) begin
          ent.rd_num = rd;
          ent.data   = data;
          mq.push_back(ent);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic            cv, cwb;
    logic [W_RD-1:0] crd;
    logic [WORD-1:0] cdata;
    logic [W_CNT-1:0] base;

    bus.v_i = 1'b1; bus.wb_i = 1'b1; bus.rd_num_i = 5'd1; bus.rd_data_i = '0;
    bus.rf_ack_i = 1'b0; chk_num = '0; rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset held with a valid EX result present.
    step(1'b1, 1'b1, 5'd1, 32'h0, 1'b0, 5'd1, 1'b1);
    step(1'b1, 1'b1, 5'd1, 32'h0, 1'b0, 5'd1, 1'b1);
    check("rst_we",      64'(bus.rf_we_o), 64'd0);
    check("rst_stall",   64'(bus.stall_o), 64'd0);
    check("rst_retired", 64'(retired),     64'd0);

    // Single write, then idle until it drains.
    step(1'b1, 1'b1, 5'd3, 32'h1234, 1'b1, 5'd0, 1'b0);
    check("single_we_next", 64'(bus.rf_we_o), 64'd1);
    check("single_num",     64'(bus.rf_num_o), 64'd3);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
    check("single_retired", 64'(retired), 64'd1);

    // Backpressure: r3 must wait while the queue is full.
    step(1'b1, 1'b1, 5'd1, 32'hA1, 1'b0, 5'd1, 1'b0);
    step(1'b1, 1'b1, 5'd2, 32'hA2, 1'b0, 5'd2, 1'b0);
    check("full_stall", 64'(bus.stall_o), 64'd1);
    step(1'b1, 1'b1, 5'd3, 32'hA3, 1'b0, 5'd3, 1'b0);
    for (int k = 0; k < 4 && mq.size() == DEPTH; k++)
      step(1'b1, 1'b1, 5'd3, 32'hA3, 1'b1, 5'd3, 1'b0);
    step(1'b1, 1'b1, 5'd3, 32'hA3, 1'b1, 5'd3, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
    check("bp_retired", 64'(retired), 64'd4);

    // Non-writing result and r0 write: retired moves, no request.
    base = retired;
    step(1'b1, 1'b0, 5'd5, 32'h55, 1'b0, 5'd5, 1'b0);
    step(1'b1, 1'b1, 5'd0, 32'h66, 1'b0, 5'd0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    check("drop_we",      64'(bus.rf_we_o), 64'd0);
    check("drop_retired", 64'(retired - base), 64'd2);

    // Hazard on a queued r7.
    step(1'b1, 1'b1, 5'd7, 32'h77, 1'b0, 5'd7, 1'b0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 1'b0);
    check("haz_hit", 64'(hazard), 64'd1);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd6, 1'b0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 1'b0);

    // Reset while full and stalled; ack during reset must not matter.
    step(1'b1, 1'b1, 5'd4, 32'hB4, 1'b0, 5'd4, 1'b0);
    step(1'b1, 1'b1, 5'd5, 32'hB5, 1'b0, 5'd4, 1'b0);
    step(1'b1, 1'b1, 5'd6, 32'hB6, 1'b1, 5'd4, 1'b1);
    check("mid_rst_we",  64'(bus.rf_we_o), 64'd0);
    check("mid_rst_haz", 64'(hazard),      64'd0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0);

    // Randomized traffic; EX holds its item while stalled.
    cv = 1'b0; cwb = 1'b0; crd = '0; cdata = '0;
    for (int n = 0; n < 400; n++) begin
      if (!(cv && mq.size() == DEPTH)) begin
        cv    = ($urandom_range(0, 3) != 0);
        cwb   = ($urandom_range(0, 4) != 0);
        crd   = W_RD'($urandom_range(0, 7));
        cdata = $urandom;
      end
      step(cv, cwb, crd, cdata, 1'($urandom_range(0, 1)),
           W_RD'($urandom_range(0, 7)), ($urandom_range(0, 59) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
